// File: rtl/uart_rx_fifo.sv
// 16x-oversampled UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN defined)
// feeding a show-ahead FIFO with a valid/ready output handshake.
module uart_rx_fifo #(
   parameter int CLK_FREQ   = 25_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       frame_err_o,
   output logic       overrun_o,
   output logic       busy_o
);

   localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW      = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_BRK
   } state_t;

   state_t          state;
   logic            rx_p0, rx_p1;
   logic            rxs;
   logic [DW-1:0]   div_cnt;
   logic            tick;
   logic [3:0]      sc;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;
   logic            mid, bit_end, start_go;
   logic            stop_dec, frame_bad, par_err;
   logic            push, pop, full, empty;
   logic [AW:0]     wptr, rptr, rptr_nxt, count;
   logic [7:0]      mem [FIFO_DEPTH];

   // Stage p0/p1: two-flop synchronizer, idles high
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rx_p0 <= 1'b1;
         rx_p1 <= 1'b1;
      end else begin
         rx_p0 <= rx_i;
         rx_p1 <= rx_p0;
      end
   end
   assign rxs = rx_p1;

   // Oversampling tick, phase-aligned to the detected start edge
   assign start_go = (state == S_IDLE) && !rxs;
   assign tick     = (div_cnt == '0);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)              div_cnt <= DW'(DIV - 1);
      else if (start_go || tick) div_cnt <= DW'(DIV - 1);
      else                      div_cnt <= div_cnt - 1'b1;
   end

   assign mid      = tick && (sc == 4'd7);
   assign bit_end  = tick && (sc == 4'd15);
   assign stop_dec = (state == S_STOP) && mid;

`ifdef UART_RX_PARITY_EN
   logic par_bit;
   assign par_err = ^{shreg, par_bit};
`else
   assign par_err = 1'b0;
`endif

   assign frame_bad = !rxs || par_err;
   assign push      = stop_dec && !frame_bad && !full;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state       <= S_IDLE;
         sc          <= 4'd0;
         bit_idx     <= 3'd0;
         busy_o      <= 1'b0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         frame_err_o <= stop_dec && frame_bad;
         overrun_o   <= stop_dec && !frame_bad && full;
         if (tick) sc <= sc + 4'd1;
         case (state)
            S_IDLE: begin
               if (!rxs) begin
                  sc     <= 4'd0;
                  state  <= S_START;
                  busy_o <= 1'b1;
               end
            end
            S_START: begin
               if (mid && rxs) begin
                  state  <= S_IDLE;
                  busy_o <= 1'b0;
               end else if (bit_end) begin
                  state   <= S_DATA;
                  bit_idx <= 3'd0;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= S_PARITY;
`else
                     state <= S_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (bit_end) state <= S_STOP;
            end
`endif
            // Leave at mid-stop so a back-to-back start edge is not missed
            S_STOP: begin
               if (mid) begin
                  if (rxs) begin
                     state  <= S_IDLE;
                     busy_o <= 1'b0;
                  end else begin
                     state <= S_BRK;
                  end
               end
            end
            S_BRK: begin
               if (rxs) begin
                  state  <= S_IDLE;
                  busy_o <= 1'b0;
               end
            end
            default: begin
               state  <= S_IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (state == S_DATA && mid) shreg <= {rxs, shreg[7:1]};
`ifdef UART_RX_PARITY_EN
      if (state == S_PARITY && mid) par_bit <= rxs;
`endif
   end

   // Output FIFO: full is judged before any same-cycle pop
   assign empty    = (wptr == rptr);
   assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign valid_o  = !empty;
   assign pop      = valid_o && ready_i;
   assign count    = wptr - rptr;
   assign rptr_nxt = rptr + 1'b1;

   always_ff @(posedge clk_i) begin
      if (push) mem[wptr[AW-1:0]] <= shreg;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wptr   <= '0;
         rptr   <= '0;
         data_o <= 8'h00;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr_nxt;
         // Registered head: forward the incoming byte when it becomes the head
         if (pop) begin
            if (count == (AW + 1)'(1)) begin
               if (push) data_o <= shreg;
            end else begin
               data_o <= mem[rptr_nxt[AW-1:0]];
            end
         end else if (empty && push) begin
            data_o <= shreg;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo; a queue-based model predicts
// received bytes and error/overrun pulse counts. Honours UART_RX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

   localparam int BIT   = 208;
   localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clk_i = 1'b0;
   logic       rstn_i;
   logic       rx_i;
   logic [7:0] data_o;
   logic       valid_o;
   logic       ready_i;
   logic       frame_err_o;
   logic       overrun_o;
   logic       busy_o;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   uart_rx_fifo #(.CLK_FREQ(25_000_000), .BAUD(115200), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .rx_i       (rx_i),
      .data_o     (data_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .frame_err_o(frame_err_o),
      .overrun_o  (overrun_o),
      .busy_o     (busy_o)
   );

   // Observation log, sampled on the falling edge
   int         cyc = 0;
   logic [7:0] got_q[$];
   int         got_cyc[$];
   int         fe_cnt = 0, ov_cnt = 0, vld_cycles = 0, first_vld = -1;

   always @(negedge clk_i) begin
      cyc++;
      if (valid_o && ready_i) begin
         got_q.push_back(data_o);
         got_cyc.push_back(cyc);
      end
      if (frame_err_o) fe_cnt++;
      if (overrun_o)   ov_cnt++;
      if (valid_o) begin
         vld_cycles++;
         if (first_vld < 0) first_vld = cyc;
      end
   end

   // Reference model state
   logic [7:0] exp_q[$];
   int         exp_fe = 0, exp_ov = 0, mdl_occ = 0, t_start = 0;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc_wait(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic clear_logs();
      got_q.delete();
      got_cyc.delete();
      exp_q.delete();
      fe_cnt = 0; ov_cnt = 0; vld_cycles = 0; first_vld = -1;
      exp_fe = 0; exp_ov = 0;
   endtask

   // Drive one frame and predict its outcome from the framing rules
   task automatic send_model(input logic [7:0] b, input logic stop_bit,
                             input logic par_flip, input logic keep_low);
      bit ok;
      t_start = cyc;
      rx_i = 1'b0;
      cyc_wait(BIT);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         cyc_wait(BIT);
      end
      if (PAR_EN) begin
         rx_i = (^b) ^ par_flip;
         cyc_wait(BIT);
      end
      rx_i = stop_bit;
      cyc_wait(BIT);
      rx_i = keep_low ? 1'b0 : 1'b1;
      ok = stop_bit && !(PAR_EN && par_flip);
      if (!ok) exp_fe++;
      else if (ready_i) exp_q.push_back(b);
      else if (mdl_occ < DEPTH) begin
         exp_q.push_back(b);
         mdl_occ++;
      end else exp_ov++;
   endtask

   task automatic compare_all(input string tag);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check({tag, "_byte"}, got_q[i], exp_q[i]);
      check({tag, "_ferr"}, fe_cnt, exp_fe);
      check({tag, "_ovr"}, ov_cnt, exp_ov);
   endtask

   initial begin
      logic [7:0] b;
      logic       sb, pf;
      int         gap, k;

      // Reset
      rx_i = 1'b1; ready_i = 1'b1; rstn_i = 1'b0;
      cyc_wait(3);
      check("rst_data", data_o, 8'h00);
      check("rst_valid", valid_o, 0);
      check("rst_ferr", frame_err_o, 0);
      check("rst_ovr", overrun_o, 0);
      check("rst_busy", busy_o, 0);
      rstn_i = 1'b1;
      cyc_wait(5);
      check("post_rst_valid", valid_o, 0);
      check("post_rst_busy", busy_o, 0);

      // Single byte with consumer ready
      clear_logs();
      send_model(8'h55, 1'b1, 1'b0, 1'b0);
      cyc_wait(20);
      compare_all("single");
      check("single_vld_cycles", vld_cycles, 1);
      check("single_latency", int'((first_vld - t_start) >= 1976 && (first_vld - t_start) <= 1984), 1);

      // Back-to-back with stalled consumer: fifth byte overruns
      clear_logs();
      ready_i = 1'b0; mdl_occ = 0;
      for (int i = 1; i <= 5; i++) send_model(8'(i), 1'b1, 1'b0, 1'b0);
      cyc_wait(5);
      check("b2b_valid", valid_o, 1);
      check("b2b_head", data_o, 8'h01);
      ready_i = 1'b1;
      cyc_wait(10);
      compare_all("b2b");
      for (int i = 1; i < got_cyc.size(); i++)
         check("b2b_consecutive", got_cyc[i] - got_cyc[i-1], 1);
      check("b2b_drained", valid_o, 0);
      mdl_occ = 0;

      // False start glitch
      clear_logs();
      rx_i = 1'b0;
      cyc_wait(50);
      check("glitch_busy", busy_o, 1);
      rx_i = 1'b1;
      cyc_wait(200);
      check("glitch_idle", busy_o, 0);
      compare_all("glitch");

      // Framing error followed by break, then a clean byte
      clear_logs();
      send_model(8'hA3, 1'b0, 1'b0, 1'b1);
      cyc_wait(1000);
      check("brk_busy", busy_o, 1);
      rx_i = 1'b1;
      cyc_wait(6);
      check("brk_release", busy_o, 0);
      cyc_wait(20);
      send_model(8'h3C, 1'b1, 1'b0, 1'b0);
      cyc_wait(20);
      compare_all("brk");

`ifdef UART_RX_PARITY_EN
      // Even-parity check on 0x07
      clear_logs();
      send_model(8'h07, 1'b1, 1'b1, 1'b0);
      cyc_wait(20);
      send_model(8'h07, 1'b1, 1'b0, 1'b0);
      cyc_wait(20);
      compare_all("parity");
`endif

      // Randomized frames, consumer ready, occasional bad stop / parity
      clear_logs();
      for (int n = 0; n < 6; n++) begin
         b   = 8'($urandom);
         sb  = ($urandom_range(0, 3) != 0);
         pf  = ($urandom_range(0, 4) == 0);
         gap = sb ? $urandom_range(0, 60) : $urandom_range(10, 60);
         send_model(b, sb, pf, 1'b0);
         cyc_wait(gap);
      end
      cyc_wait(20);
      compare_all("rand");

      // Randomized stall burst
      clear_logs();
      ready_i = 1'b0; mdl_occ = 0;
      k = $urandom_range(3, 5);
      for (int n = 0; n < k; n++) send_model(8'($urandom), 1'b1, 1'b0, 1'b0);
      cyc_wait(5);
      ready_i = 1'b1;
      cyc_wait(10);
      compare_all("rand_stall");
      mdl_occ = 0;

      // Reset mid-frame with a byte waiting in the FIFO
      clear_logs();
      ready_i = 1'b0;
      send_model(8'h11, 1'b1, 1'b0, 1'b0);
      cyc_wait(5);
      check("midrst_pre_valid", valid_o, 1);
      rx_i = 1'b0;
      cyc_wait(BIT * 3);
      check("midrst_busy", busy_o, 1);
      rstn_i = 1'b0;
      cyc_wait(2);
      check("midrst_valid", valid_o, 0);
      check("midrst_busy_clr", busy_o, 0);
      rx_i = 1'b1;
      rstn_i = 1'b1;
      ready_i = 1'b1;
      cyc_wait(BIT * 8);
      check("midrst_no_push", got_q.size(), 0);
      check("midrst_no_ferr", fe_cnt, 0);
      check("midrst_idle", busy_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
